// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, op          issue request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_data, rt_data   operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   cancel             pipeline flush, aborts an in-flight operation
//   hi_we, lo_we       MTHI / MTLO write enables, wdata is the write data
//   busy               operation in flight
//   done               one-cycle pulse when hi/lo first show a new result
//   hi, lo             architectural HI and LO registers
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;      // multiplicand for multiply, divisor for divide
  logic [2*WIDTH-1:0] acc;       // {partial product | multiplier} or {remainder | quotient}
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand conditioning at issue
  logic             signed_op;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  // One iteration of each algorithm
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Sign fixup
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !cancel) state_next = CALC;
      CALC: begin
        if (cancel)                  state_next = IDLE;
        else if (count == LAST_ITER) state_next = FIXUP;
      end
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    signed_op = ~op[0];
    // Two's-complement negation leaves 0x80..0 unchanged, which is its
    // correct magnitude when read as unsigned.
    rs_mag = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_mag = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Shift-add: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right, consuming one multiplier bit.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {add_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only when it does not borrow.
    div_shifted = acc[2*WIDTH-1:WIDTH-1];
    div_diff    = {1'b0, div_shifted} - {2'b00, opnd};
    if (!div_diff[WIDTH+1])
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod_fix = neg_q ? -acc : acc;
    quot_fix = (neg_q && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // With a zero divisor the remainder holds |rs|; negating by sign(rs)
    // restores the raw rs_data, so no separate bypass path is needed.
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start && !cancel) begin
            count    <= '0;
            is_div   <= op[1];
            neg_q    <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r    <= signed_op & rs_data[WIDTH-1];
            div_zero <= op[1] & (rt_data == '0);
            if (op[1]) begin
              opnd <= rt_mag;
              acc  <= {{WIDTH{1'b0}}, rs_mag};
            end else begin
              opnd <= rs_mag;
              acc  <= {{WIDTH{1'b0}}, rt_mag};
            end
          end
        end
        CALC: begin
          if (!cancel) begin
            acc   <= is_div ? div_next : mul_next;
            count <= count + 1'b1;
          end
        end
        FIXUP: begin
          if (!cancel) begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op and observe up to 45 cycles. inj_kind: 0 none,
  // 1 start+lo_we while busy, 2 cancel, 3 reset; applied during cycle inj_cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cycle, input int inj_kind,
                        output int busy_cnt, output int done_cnt, output int done_at,
                        output logic [31:0] hi_s, output logic [31:0] lo_s);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_s = hi;
    lo_s = lo;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = k;
          hi_s = hi;
          lo_s = lo;
        end
      end
      if (k == inj_cycle) begin
        case (inj_kind)
          1: begin start = 1'b1; op = OP_DIVU; rs_data = 32'd99; rt_data = 32'd5;
                   lo_we = 1'b1; wdata = 32'h0000_DEAD; end
          2: cancel = 1'b1;
          3: reset  = 1'b1;
          default: ;
        endcase
      end
      if (k == inj_cycle + 1) begin
        start = 1'b0; lo_we = 1'b0; cancel = 1'b0; reset = 1'b0;
      end
    end
  endtask

  task automatic mt_write(input logic is_hi, input logic [31:0] d);
    @(negedge clk);
    hi_we = is_hi; lo_we = ~is_hi; wdata = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  int bc, dc, da;
  logic [31:0] hs, ls;

  initial begin
    vecs[0]  = '{"multu_111111x222222", OP_MULTU, 32'd111111,     32'd222222,     32'h0000_0005, 32'hBFB7_7862};
    vecs[1]  = '{"mult_m7x3",           OP_MULT,  32'hFFFF_FFF9,  32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{"multu_max_sq",        OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3]  = '{"mult_min_sq",         OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    vecs[4]  = '{"mult_0xm1",           OP_MULT,  32'h0000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{"divu_100_7",          OP_DIVU,  32'd100,        32'd7,          32'd2,         32'd14};
    vecs[6]  = '{"div_m7_2",            OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[7]  = '{"div_7_m2",            OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{"div_min_m1",          OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
    vecs[9]  = '{"div_5_0",             OP_DIV,   32'd5,          32'd0,          32'd5,         32'hFFFF_FFFF};
    vecs[10] = '{"div_m5_0",            OP_DIV,   32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[11] = '{"divu_max_16",         OP_DIVU,  32'hFFFF_FFFF,  32'd16,         32'h0000_000F, 32'h0FFF_FFFF};

    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, bc, dc, da, hs, ls);
      check({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd33);
      check({vecs[i].name, "_done_count"},  64'(dc), 64'd1);
      check({vecs[i].name, "_done_cycle"},  64'(da), 64'd34);
      check({vecs[i].name, "_hi"}, 64'(hs), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"}, 64'(ls), 64'(vecs[i].exp_lo));
    end

    // MTHI in idle, visible next cycle with no done
    mt_write(1'b1, 32'h0000_1234);
    @(negedge clk);
    check("mthi_value", 64'(hi), 64'h1234);
    check("mthi_no_done", 64'(done), 64'h0);

    // Start and MTLO while busy are ignored
    run_op(OP_MULTU, 32'd2, 32'd3, 10, 1, bc, dc, da, hs, ls);
    check("busy_ignore_busy_cycles", 64'(bc), 64'd33);
    check("busy_ignore_done_count",  64'(dc), 64'd1);
    check("busy_ignore_hi", 64'(hs), 64'h0);
    check("busy_ignore_lo", 64'(ls), 64'd6);
    check("busy_ignore_idle_after", 64'(busy), 64'h0);

    // Start together with cancel in idle is ignored
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = OP_MULTU; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("start_cancel_idle_busy", 64'(busy), 64'h0);

    // Cancel mid-divide keeps prior hi/lo
    mt_write(1'b1, 32'h0000_ABCD);
    mt_write(1'b0, 32'h0000_5555);
    run_op(OP_DIV, 32'd100, 32'd7, 5, 2, bc, dc, da, hs, ls);
    check("cancel_busy_cycles", 64'(bc), 64'd5);
    check("cancel_done_count",  64'(dc), 64'd0);
    check("cancel_hi", 64'(hi), 64'h0000_ABCD);
    check("cancel_lo", 64'(lo), 64'h0000_5555);

    // Reset mid-multiply clears everything
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 20, 3, bc, dc, da, hs, ls);
    check("reset_mid_busy_cycles", 64'(bc), 64'd20);
    check("reset_mid_done_count",  64'(dc), 64'd0);
    check("reset_mid_hi", 64'(hi), 64'h0);
    check("reset_mid_lo", 64'(lo), 64'h0);

    // A fresh op afterwards completes normally
    run_op(OP_MULTU, 32'd111111, 32'd222222, 0, 0, bc, dc, da, hs, ls);
    check("post_reset_done_cycle", 64'(da), 64'd34);
    check("post_reset_hi", 64'(hs), 64'h5);
    check("post_reset_lo", 64'(ls), 64'hBFB7_7862);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
